// File: rtl/call_request_register_pkg.sv
// Shared elevator constants: floor counts, floor index width, clear_dir encodings.
// Helper functions build per-floor bit masks for the call vectors.
package elevator_pkg;

  localparam int unsigned N_FLOORS_DEFAULT = 8;
  localparam int unsigned MAX_FLOORS       = 8;
  localparam int unsigned FLOOR_W          = 4;

  localparam logic [1:0] DIR_UP   = 2'b10;
  localparam logic [1:0] DIR_DOWN = 2'b01;

  function automatic logic [MAX_FLOORS-1:0] floor_mask(input int unsigned n);
    logic [MAX_FLOORS-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < MAX_FLOORS; i++) begin
      m[i] = (i < n);
    end
    return m;
  endfunction

  function automatic logic [MAX_FLOORS-1:0] floor_bit(input logic [FLOOR_W-1:0] f);
    return MAX_FLOORS'(1) << f;
  endfunction

endpackage

// File: rtl/call_request_register_debouncer.sv
// Single-input debouncer: sync flop, mismatch counter, debounced level and a
// one-cycle press pulse on each debounced rising transition.
module btn_debouncer #(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic press
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES);

  logic          sync_q;
  logic          level_q, level_d;
  logic          prev_q;
  logic          press_q;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (sync_q != level_q) begin
      if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
        level_d = sync_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  // Press comes from the registered level edge, so it trails the flip by one clock.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q  <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
      prev_q  <= 1'b0;
      press_q <= 1'b0;
    end else begin
      sync_q  <= raw;
      level_q <= level_d;
      cnt_q   <= cnt_d;
      prev_q  <= level_q;
      press_q <= level_q & ~prev_q;
    end
  end

  assign level = level_q;
  assign press = press_q;

endmodule

// File: rtl/call_request_register.sv
// Elevator call request register: debounces hall/cabin buttons and holds pending calls
// until served. Optional macro CALL_CANCEL_EN: cabin re-press cancels a pending cabin call.
module call_request_register
  import elevator_pkg::*;
#(
  parameter int unsigned N_FLOORS        = N_FLOORS_DEFAULT,
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [15:0]           sw,
  input  logic                  btnu,
  input  logic                  btnd,
  input  logic [FLOOR_W-1:0]    cur_floor,
  input  logic                  clear_valid,
  input  logic [1:0]            clear_dir,
  output logic [MAX_FLOORS-1:0] up_call,
  output logic [MAX_FLOORS-1:0] down_call,
  output logic [MAX_FLOORS-1:0] cabin_call,
  output logic                  any_call,
  output logic                  new_call
);

  localparam logic [MAX_FLOORS-1:0] VALID   = floor_mask(N_FLOORS);
  localparam logic [FLOOR_W-1:0]    NF_W    = FLOOR_W'(N_FLOORS);
  localparam logic [FLOOR_W-1:0]    TOP_W   = FLOOR_W'(N_FLOORS - 1);
  localparam int unsigned           N_INPUT = 2 + MAX_FLOORS;

  logic [N_INPUT-1:0]    raw_vec, press_vec, unused_level;
  logic [4:0]            unused_sw;
  logic [FLOOR_W-1:0]    hsel;
  logic [MAX_FLOORS-1:0] set_up, set_dn, set_cab, clr_cab, clr_up, clr_dn;
  logic [MAX_FLOORS-1:0] up_q, up_d, dn_q, dn_d, cab_q, cab_d;
  logic                  any_q, any_d, new_q, new_d;

  assign raw_vec   = {sw[15:8], btnd, btnu};
  assign unused_sw = sw[7:3];

  for (genvar g = 0; g < N_INPUT; g++) begin : g_deb
    btn_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
      .clk  (clk),
      .rst  (rst),
      .raw  (raw_vec[g]),
      .level(unused_level[g]),
      .press(press_vec[g])
    );
  end

  assign hsel = {1'b0, sw[2:0]};

  always_comb begin
    set_up  = '0;
    set_dn  = '0;
    clr_cab = '0;
    if (press_vec[0] && (hsel < NF_W) && (hsel != TOP_W)) set_up = floor_bit(hsel);
    if (press_vec[1] && (hsel < NF_W) && (hsel != '0))    set_dn = floor_bit(hsel);
    set_cab = press_vec[N_INPUT-1:2] & VALID;
    if (clear_valid && (cur_floor < NF_W)) clr_cab = floor_bit(cur_floor);
    clr_up = (|(clear_dir & DIR_UP))   ? clr_cab : '0;
    clr_dn = (|(clear_dir & DIR_DOWN)) ? clr_cab : '0;

    // Clear is applied after set so a same-cycle serve always wins.
    up_d  = (up_q | set_up) & ~clr_up & VALID;
    dn_d  = (dn_q | set_dn) & ~clr_dn & VALID;
`ifdef CALL_CANCEL_EN
    cab_d = (cab_q ^ set_cab) & ~clr_cab & VALID;
`else
    cab_d = (cab_q | set_cab) & ~clr_cab & VALID;
`endif
    new_d = |((up_d & ~up_q) | (dn_d & ~dn_q) | (cab_d & ~cab_q));
    any_d = |{up_d, dn_d, cab_d};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      up_q  <= '0;
      dn_q  <= '0;
      cab_q <= '0;
      any_q <= 1'b0;
      new_q <= 1'b0;
    end else begin
      up_q  <= up_d;
      dn_q  <= dn_d;
      cab_q <= cab_d;
      any_q <= any_d;
      new_q <= new_d;
    end
  end

  assign up_call    = up_q;
  assign down_call  = dn_q;
  assign cabin_call = cab_q;
  assign any_call   = any_q;
  assign new_call   = new_q;

endmodule
